// File: rtl/fifo_flex.sv
// Synchronous FIFO with selectable registered-read or first-word-fall-through output,
// occupancy level, almost-full/empty thresholds and sticky overflow/underflow flags.
module fifo_flex #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AF_THRESH  = DEPTH - 2,
  parameter int unsigned AE_THRESH  = 1,
  parameter bit          FWFT       = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        write_en,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  logic                        read_en,
  input  logic                        flush,
  input  logic                        clr_flags,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic [$clog2(DEPTH):0]      fifo_level,
  output logic                        fifo_full,
  output logic                        fifo_empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  rd_acc, wr_acc;

  // Accept logic, pointer/level next state and flags derived from the next level
  always_comb begin
    rd_acc   = read_en && !empty_q && !flush;
    wr_acc   = write_en && !flush && (!full_q || rd_acc);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
    full_d  = (level_d == LW'(DEPTH));
    empty_d = (level_d == '0);
    af_d    = (32'(level_d) >= AF_THRESH);
    ae_d    = (32'(level_d) <= AE_THRESH);
    // A new error in the same cycle wins over clr_flags
    ovf_d = (write_en && !flush && !wr_acc) ? 1'b1 : (clr_flags ? 1'b0 : ovf_q);
    udf_d = (read_en  && !flush && !rd_acc) ? 1'b1 : (clr_flags ? 1'b0 : udf_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= (AF_THRESH == 0);
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

  generate
    if (FWFT) begin : g_fwft
      assign data_out = empty_q ? '0 : mem_q[rd_ptr_q];
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] dout_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)         dout_q <= '0;
        else if (rd_acc) dout_q <= mem_q[rd_ptr_q];
      end
      assign data_out = dout_q;
    end
  endgenerate

  assign fifo_level   = level_q;
  assign fifo_full    = full_q;
  assign fifo_empty   = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_flex.sv
// Bench for fifo_flex: registered-read and FWFT instances driven in lockstep and
// compared every cycle against a queue-based reference model.
module tb_fifo_flex;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AF    = 6;
  localparam int unsigned AE    = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          write_en, read_en, flush, clr_flags;
  logic [DW-1:0] data_in;

  logic [DW-1:0] dout0, dout1;
  logic [3:0]    lvl0, lvl1;
  logic          full0, full1, empty0, empty1, af0, af1, ae0, ae1;
  logic          ovf0, ovf1, udf0, udf1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout0;
  logic          m_ovf, m_udf;

  always #5 clk = ~clk;

  fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .write_en(write_en), .data_in(data_in), .read_en(read_en),
    .flush(flush), .clr_flags(clr_flags), .data_out(dout0), .fifo_level(lvl0),
    .fifo_full(full0), .fifo_empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .overflow(ovf0), .underflow(udf0)
  );

  fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .write_en(write_en), .data_in(data_in), .read_en(read_en),
    .flush(flush), .clr_flags(clr_flags), .data_out(dout1), .fifo_level(lvl1),
    .fifo_full(full1), .fifo_empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .overflow(ovf1), .underflow(udf1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int unsigned sz;
    logic [DW-1:0] fw;
    sz = mq.size();
    fw = (sz == 0) ? '0 : mq[0];
    check("level0", 32'(lvl0), sz);
    check("level1", 32'(lvl1), sz);
    check("full0",  32'(full0),  32'(sz == DEPTH));
    check("full1",  32'(full1),  32'(sz == DEPTH));
    check("empty0", 32'(empty0), 32'(sz == 0));
    check("empty1", 32'(empty1), 32'(sz == 0));
    check("afull0", 32'(af0), 32'(sz >= AF));
    check("afull1", 32'(af1), 32'(sz >= AF));
    check("aempty0", 32'(ae0), 32'(sz <= AE));
    check("aempty1", 32'(ae1), 32'(sz <= AE));
    check("ovf0", 32'(ovf0), 32'(m_ovf));
    check("ovf1", 32'(ovf1), 32'(m_ovf));
    check("udf0", 32'(udf0), 32'(m_udf));
    check("udf1", 32'(udf1), 32'(m_udf));
    check("dout_reg",  32'(dout0), 32'(m_dout0));
    check("dout_fwft", 32'(dout1), 32'(fw));
  endtask

  // One clock cycle: drive inputs, advance the model by the FIFO rules, check after the edge
  task automatic step(input logic we, input logic [DW-1:0] d, input logic re,
                      input logic fl, input logic cf);
    logic rd_ok, wr_ok;
    write_en = we; data_in = d; read_en = re; flush = fl; clr_flags = cf;
    rd_ok = re && !fl && (mq.size() > 0);
    wr_ok = we && !fl && ((mq.size() < DEPTH) || rd_ok);
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (rd_ok) m_dout0 = mq.pop_front();
      if (wr_ok) mq.push_back(d);
    end
    if (we && !fl && !wr_ok) m_ovf = 1'b1;
    else if (cf)             m_ovf = 1'b0;
    if (re && !fl && !rd_ok) m_udf = 1'b1;
    else if (cf)             m_udf = 1'b0;
    #1;
    check_all();
  endtask

  task automatic idle();
    write_en = 1'b0; data_in = '0; read_en = 1'b0; flush = 1'b0; clr_flags = 1'b0;
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic mid_reset();
    idle();
    #2 rst = 1'b1;
    #1;
    mq.delete(); m_dout0 = '0; m_ovf = 1'b0; m_udf = 1'b0;
    check_all();
    #2 rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    mq.delete(); m_dout0 = '0; m_ovf = 1'b0; m_udf = 1'b0;
    #3;
    check_all();
    rst = 1'b0;

    // Fill 1..8 then drain
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Simultaneous read/write at full and at empty
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'd10, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'd5, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // FWFT fall-through then pop
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Flush with pointers mid-buffer, then refill across the wrap
    for (int i = 1; i <= 5; i++) step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Reset at level 4, then write on the first edge after release
    for (int i = 1; i <= 4; i++) step(1'b1, DW'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    mid_reset();
    step(1'b1, 8'd7, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Random traffic with occasional flush, flag clear and reset
    for (int n = 0; n < 600; n++) begin
      logic we, re, fl, cf;
      int unsigned bias;
      bias = (n / 100) % 3;
      we = ($urandom_range(99) < (bias == 0 ? 70 : (bias == 1 ? 30 : 50)));
      re = ($urandom_range(99) < (bias == 0 ? 30 : (bias == 1 ? 70 : 50)));
      fl = ($urandom_range(99) < 2);
      cf = ($urandom_range(99) < 5);
      if ($urandom_range(199) == 0) mid_reset();
      step(we, DW'($urandom), re, fl, cf);
    end

    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_flex.md
FIFO_FLEX -- requirements
Module: fifo_flex

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, entry count; power of two, >= 2.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2, almost-full threshold in entries.
REQ-004 SHALL have parameter AE_THRESH, default 1, almost-empty threshold in entries.
REQ-005 SHALL have parameter FWFT, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 SHALL have port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port write_en, input, 1, write request.
REQ-009 SHALL have port data_in, input, DATA_WIDTH, write data.
REQ-010 SHALL have port read_en, input, 1, read (pop) request.
REQ-011 SHALL have port flush, input, 1, synchronous clear of contents.
REQ-012 SHALL have port clr_flags, input, 1, synchronous clear of sticky error flags.
REQ-013 SHALL have port data_out, output, DATA_WIDTH, read data.
REQ-014 SHALL have port fifo_level, output, $clog2(DEPTH)+1, current occupancy, 0..DEPTH.
REQ-015 SHALL have ports fifo_full and fifo_empty, output, 1 each; fifo_full = (level==DEPTH), fifo_empty = (level==0).
REQ-016 SHALL have ports almost_full and almost_empty, output, 1 each.
REQ-017 SHALL have ports overflow and underflow, output, 1 each, sticky error flags.

Function
REQ-018 SHALL accept a read iff read_en=1, fifo_empty=0 and flush=0.
REQ-019 SHALL accept a write iff write_en=1, flush=0, and either fifo_full=0 or a read is accepted in the same cycle.
REQ-020 SHALL update level on each edge: +1 for write only, -1 for read only, unchanged for both or neither.
REQ-021 SHALL, when empty with write_en=read_en=1, accept the write, reject the read, and set underflow.
REQ-022 SHALL store accepted writes at wr_ptr and advance wr_ptr by one modulo DEPTH; rd_ptr SHALL advance the same way on accepted reads.
REQ-023 SHALL, with flush=1, set both pointers and level to 0 on the next edge and ignore read_en/write_en; memory contents and sticky flags are untouched.
REQ-024 SHALL, in FWFT=0, register the entry at rd_ptr into data_out on the edge that accepts a read (valid one cycle after read_en is sampled) and hold data_out otherwise, including across flush.
REQ-025 SHALL, in FWFT=1, drive data_out combinationally from the entry at rd_ptr when fifo_empty=0 and drive 0 when fifo_empty=1. A word written into an empty FIFO SHALL appear on the edge after the write. read_en pops the displayed word.
REQ-026 SHALL drive almost_full = (level >= AF_THRESH) and almost_empty = (level <= AE_THRESH), derived from the registered level with no added latency.
REQ-027 SHALL set overflow on the edge where write_en=1, flush=0 and the write is rejected. It SHALL set underflow on the edge where read_en=1, flush=0 and the read is rejected.
REQ-028 SHALL clear overflow and underflow on the edge where clr_flags=1. A same-cycle set takes priority over clear.
REQ-029 SHALL never change memory, pointers or level on a rejected request.

Reset
REQ-030 SHALL, on rst=1 and independent of clk, force pointers, level, overflow and underflow to 0. This gives fifo_empty=1, fifo_full=0, almost_empty=1 and almost_full=(AF_THRESH==0).
REQ-031 SHALL reset data_out to 0 in both modes.
REQ-032 SHALL not require memory contents to be reset.
REQ-033 SHALL recover from reset asserted mid-operation identically to power-up, and SHALL accept a write on the first edge after rst deasserts.

Verification (DEPTH=8, DATA_WIDTH=8, AF_THRESH=6, AE_THRESH=1)
REQ-034 SHALL verify fill/drain with FWFT=0:
  - stimulus: write 1..8, then read 8 times.
  - required: data_out = 1..8 in order, each one cycle after its read.
  - required: level steps 0..8..0; fifo_full only at 8; almost_full at levels >= 6; almost_empty at levels <= 1.
REQ-035 SHALL verify overflow and clr_flags: at level 8, write 0x99.
  - required: level stays 8, overflow=1, and 0x99 is never read out.
  - then pulse clr_flags: overflow=0.
REQ-036 SHALL verify simultaneous read/write:
  - at full with contents 1..8, read and write 10 in the same cycle: level stays 8, data_out=1, no overflow; the eighth subsequent read returns 10.
  - at empty, read and write 5 in the same cycle: level=1, underflow=1.
REQ-037 SHALL verify FWFT=1:
  - write 0xA5 to an empty FIFO: data_out=0xA5 on the edge after the write with no read.
  - pulse read_en: fifo_empty=1 and data_out=0.
REQ-038 SHALL verify flush and wrap: write 1..5, read 3, flush.
  - required: level=0 and fifo_empty=1.
  - then write 1..8: all are accepted and read back 1..8, exercising pointer wrap.
REQ-039 SHALL verify mid-operation reset: assert rst asynchronously mid-cycle at level 4.
  - required: level=0, fifo_empty=1, data_out=0 immediately.
  - after release, write 7 then read: data_out=7.
